// File: rtl/core_dmem_responder.sv
// core_dmem_responder: core data-memory port to Wishbone classic bridge.
// Ports: i_clk/i_rst, core req side (i_mem_*), core resp side
// (o_mem_data/o_mem_ack/o_mem_exception), Wishbone master (wb_*).
`timescale 1ns/1ps

module core_dmem_responder #(
  parameter int RW      = 16,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mem_req,
  input  logic             i_mem_we,
  input  logic [RW-1:0]    i_mem_addr,
  input  logic [RW-1:0]    i_mem_data,
  input  logic [SEL_W-1:0] i_mem_sel,
  input  logic             i_mem_long,
  input  logic [7:0]       i_mem_addr_high,
  output logic [RW-1:0]    o_mem_data,
  output logic             o_mem_ack,
  output logic             o_mem_exception,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [23:0]      wb_adr,
  output logic [RW-1:0]    wb_o_dat,
  output logic [SEL_W-1:0] wb_sel,
  input  logic [RW-1:0]    wb_i_dat,
  input  logic             wb_ack,
  input  logic             wb_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  // Last counter value before the bus cycle is abandoned;
  // counter starts at 0 so stb stays high TIMEOUT cycles.
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic             r_cyc;
  logic             r_stb;
  logic             r_we;
  logic [23:0]      r_adr;
  logic [RW-1:0]    r_wdat;
  logic [SEL_W-1:0] r_sel;
  logic [RW-1:0]    r_rdat;
  logic             r_ack;
  logic             r_exc;

  logic [7:0]       w_adr_hi;

  assign w_adr_hi = i_mem_long ? i_mem_addr_high : 8'h00;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_sel   <= '0;
      r_rdat  <= '0;
      r_ack   <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_exc <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_mem_req) begin
            r_we    <= i_mem_we;
            r_sel   <= i_mem_sel;
            r_wdat  <= i_mem_data;
            r_adr   <= {w_adr_hi, i_mem_addr};
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          if (wb_err) begin
            // err dominates a simultaneous ack
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_ack   <= 1'b1;
            r_exc   <= 1'b1;
            r_state <= S_RESP;
          end else if (wb_ack) begin
            if (!r_we) begin
              r_rdat <= wb_i_dat;
            end
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= S_RESP;
          end else if (r_cnt == LP_LAST) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_ack   <= 1'b1;
            r_exc   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          // req still high here belongs to the
          // transfer being completed
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_cyc          = r_cyc;
  assign wb_stb          = r_stb;
  assign wb_we           = r_we;
  assign wb_adr          = r_adr;
  assign wb_o_dat        = r_wdat;
  assign wb_sel          = r_sel;
  assign o_mem_data      = r_rdat;
  assign o_mem_ack       = r_ack;
  assign o_mem_exception = r_exc;

endmodule

// File: tb/tb_core_dmem_responder.sv
// tb_core_dmem_responder: directed and randomized transfers
// against a transaction-level model of the responder.
`timescale 1ns/1ps

module tb_core_dmem_responder;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_sel;
  logic        mem_long;
  logic [7:0]  mem_hi;
  logic [15:0] o_mem_data;
  logic        o_mem_ack;
  logic        o_mem_exception;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [23:0] wb_adr;
  logic [15:0] wb_o_dat;
  logic [1:0]  wb_sel;
  logic [15:0] wb_dat;
  logic        wb_ack;
  logic        wb_err;

  int          n_checks;
  int          n_errors;
  logic [15:0] exp_mdata;

  core_dmem_responder #(
    .RW(16),
    .SEL_W(2),
    .TIMEOUT(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_mem_req(mem_req),
    .i_mem_we(mem_we),
    .i_mem_addr(mem_addr),
    .i_mem_data(mem_data),
    .i_mem_sel(mem_sel),
    .i_mem_long(mem_long),
    .i_mem_addr_high(mem_hi),
    .o_mem_data(o_mem_data),
    .o_mem_ack(o_mem_ack),
    .o_mem_exception(o_mem_exception),
    .wb_cyc(wb_cyc),
    .wb_stb(wb_stb),
    .wb_we(wb_we),
    .wb_adr(wb_adr),
    .wb_o_dat(wb_o_dat),
    .wb_sel(wb_sel),
    .wb_i_dat(wb_dat),
    .wb_ack(wb_ack),
    .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  // Presents one request (called just after a rising edge)
  // and plays a slave that answers on stb cycle waits+1.
  // kind: 0 ack, 1 err, 2 err+ack, 3 silent.
  // Cycle k=0 is the request cycle; lat is the k of o_mem_ack.
  task automatic run_xfer(
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    input  logic [1:0]  sel,
    input  logic        lng,
    input  logic [7:0]  hi,
    input  int          waits,
    input  int          kind,
    input  logic [15:0] rdata,
    input  int          tail,
    output int          stb_n,
    output int          lat,
    output logic        exc,
    output logic [15:0] mdata,
    output logic        adr_ok,
    output int          acks
  );
    logic [23:0] eadr;
    int          k;
    bit          done;
    eadr   = {lng ? hi : 8'h00, addr};
    stb_n  = 0;
    lat    = -1;
    exc    = 1'b0;
    mdata  = '0;
    adr_ok = 1'b1;
    acks   = 0;
    done   = 0;
    k      = 0;
    mem_req  = 1'b1;
    mem_we   = we;
    mem_addr = addr;
    mem_data = data;
    mem_sel  = sel;
    mem_long = lng;
    mem_hi   = hi;
    while (!done && k < 40) begin
      @(negedge clk);
      if (wb_stb) begin
        stb_n++;
        if (wb_adr !== eadr || wb_we !== we ||
            wb_sel !== sel || wb_o_dat !== data ||
            wb_cyc !== 1'b1)
          adr_ok = 1'b0;
      end
      if (o_mem_ack) begin
        acks++;
        lat   = k;
        exc   = o_mem_exception;
        mdata = o_mem_data;
        done  = 1;
      end
      if (wb_stb && kind != 3 && stb_n == waits + 1) begin
        wb_ack = (kind == 0 || kind == 2);
        wb_err = (kind == 1 || kind == 2);
        wb_dat = rdata;
      end else begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_dat = 16'($urandom);
      end
      @(posedge clk);
      #1;
      k++;
    end
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (tail > 0) begin
      mem_req = 1'b0;
      for (int t = 0; t < tail; t++) begin
        @(negedge clk);
        if (o_mem_ack) acks++;
        if (wb_stb) stb_n++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctl: cyc/stb/we=%b%b%b want 000",
               wb_cyc, wb_stb, wb_we);
    end
    n_checks++;
    if (o_mem_ack !== 1'b0 || o_mem_exception !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_resp: ack/exc=%b%b want 00",
               o_mem_ack, o_mem_exception);
    end
    n_checks++;
    if (wb_adr !== 24'h0 || wb_o_dat !== 16'h0 ||
        wb_sel !== 2'b00 || o_mem_data !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_data: adr=%h dat=%h sel=%b md=%h want 0",
               wb_adr, wb_o_dat, wb_sel, o_mem_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_zero_wait;
    int s, l, a;
    logic e, ok;
    logic [15:0] md;
    run_xfer(1'b0, 16'h1234, 16'h0000, 2'b11, 1'b0, 8'h77,
             0, 0, 16'hBEEF, 3, s, l, e, md, ok, a);
    exp_mdata = 16'hBEEF;
    n_checks++;
    if (l !== 2) begin
      n_errors++; $display("FAIL rd0_lat: got %0d want 2", l);
    end
    n_checks++;
    if (md !== exp_mdata || e !== 1'b0) begin
      n_errors++;
      $display("FAIL rd0_data: got %h/%b want %h/0", md, e, exp_mdata);
    end
    n_checks++;
    if (ok !== 1'b1 || s !== 1 || a !== 1) begin
      n_errors++;
      $display("FAIL rd0_bus: ok=%b stb=%0d acks=%0d want 1/1/1",
               ok, s, a);
    end
  endtask

  task automatic test_long_write;
    int s, l, a;
    logic e, ok;
    logic [15:0] md;
    run_xfer(1'b1, 16'h0010, 16'h00CD, 2'b01, 1'b1, 8'hA5,
             3, 0, 16'h5555, 3, s, l, e, md, ok, a);
    n_checks++;
    if (ok !== 1'b1 || s !== 4) begin
      n_errors++;
      $display("FAIL lwr_bus: ok=%b stb=%0d want 1/4", ok, s);
    end
    n_checks++;
    if (l !== 5 || a !== 1 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL lwr_ack: lat=%0d acks=%0d exc=%b want 5/1/0",
               l, a, e);
    end
    n_checks++;
    if (md !== exp_mdata) begin
      n_errors++;
      $display("FAIL lwr_mdata: got %h want %h", md, exp_mdata);
    end
  endtask

  task automatic test_bus_error;
    int s, l, a;
    logic e, ok;
    logic [15:0] md;
    run_xfer(1'b0, 16'h4000, 16'h0000, 2'b11, 1'b0, 8'h00,
             1, 2, 16'hDEAD, 3, s, l, e, md, ok, a);
    n_checks++;
    if (e !== 1'b1 || a !== 1 || l !== 3) begin
      n_errors++;
      $display("FAIL err_ack: exc=%b acks=%0d lat=%0d want 1/1/3",
               e, a, l);
    end
    n_checks++;
    if (md !== exp_mdata || o_mem_data !== exp_mdata) begin
      n_errors++;
      $display("FAIL err_mdata: got %h/%h want %h",
               md, o_mem_data, exp_mdata);
    end
  endtask

  task automatic test_timeout;
    int s, l, a;
    logic e, ok;
    logic [15:0] md;
    run_xfer(1'b0, 16'h0BAD, 16'h0000, 2'b10, 1'b1, 8'h3C,
             0, 3, 16'h0000, 4, s, l, e, md, ok, a);
    n_checks++;
    if (s !== TO || ok !== 1'b1) begin
      n_errors++;
      $display("FAIL to_stb: got %0d cycles ok=%b want %0d",
               s, ok, TO);
    end
    n_checks++;
    if (l !== TO + 1 || e !== 1'b1 || a !== 1) begin
      n_errors++;
      $display("FAIL to_ack: lat=%0d exc=%b acks=%0d want %0d/1/1",
               l, e, a, TO + 1);
    end
    n_checks++;
    if (wb_cyc !== 1'b0 || md !== exp_mdata) begin
      n_errors++;
      $display("FAIL to_after: cyc=%b md=%h want 0/%h",
               wb_cyc, md, exp_mdata);
    end
  endtask

  task automatic test_back_to_back;
    int s, l, a;
    logic e, ok;
    logic [15:0] md;
    run_xfer(1'b0, 16'h0100, 16'h0000, 2'b11, 1'b0, 8'h00,
             0, 0, 16'h1111, 0, s, l, e, md, ok, a);
    exp_mdata = 16'h1111;
    n_checks++;
    if (l !== 2 || md !== exp_mdata || s !== 1) begin
      n_errors++;
      $display("FAIL b2b_first: lat=%0d md=%h stb=%0d want 2/%h/1",
               l, md, s, exp_mdata);
    end
    run_xfer(1'b0, 16'h0200, 16'h0000, 2'b11, 1'b1, 8'h12,
             1, 0, 16'h2222, 3, s, l, e, md, ok, a);
    exp_mdata = 16'h2222;
    n_checks++;
    if (s !== 2 || ok !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_second_bus: stb=%0d ok=%b want 2/1", s, ok);
    end
    n_checks++;
    if (l !== 3 || md !== exp_mdata || a !== 1) begin
      n_errors++;
      $display("FAIL b2b_second_ack: lat=%0d md=%h acks=%0d want 3/%h/1",
               l, md, a, exp_mdata);
    end
  endtask

  task automatic test_async_reset;
    int s, l, a, na;
    logic e, ok;
    logic [15:0] md;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 16'h7777;
    mem_long = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_stb !== 1'b1) begin
      n_errors++; $display("FAIL ar_busy: stb=%b want 1", wb_stb);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_drop: cyc/stb=%b%b want 00", wb_cyc, wb_stb);
    end
    mem_req = 1'b0;
    exp_mdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    na = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_mem_ack || wb_stb) na++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (na !== 0) begin
      n_errors++;
      $display("FAIL ar_quiet: got %0d ack/stb cycles want 0", na);
    end
    run_xfer(1'b0, 16'h0042, 16'h0000, 2'b11, 1'b0, 8'h00,
             2, 0, 16'hCAFE, 2, s, l, e, md, ok, a);
    exp_mdata = 16'hCAFE;
    n_checks++;
    if (l !== 4 || md !== exp_mdata || e !== 1'b0 || a !== 1) begin
      n_errors++;
      $display("FAIL ar_next: lat=%0d md=%h exc=%b acks=%0d want 4/%h/0/1",
               l, md, e, a, exp_mdata);
    end
  endtask

  task automatic test_random;
    int s, l, a, r, kind, waits, tail;
    int exp_s, exp_l;
    logic e, ok, we, lng;
    logic [15:0] md, addr, data, rdata;
    logic [1:0] sel;
    logic [7:0] hi;
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 7);
      kind = (r == 4) ? 1 : (r == 5) ? 2 : (r == 6) ? 3 : 0;
      waits = $urandom_range(0, 5);
      tail  = $urandom_range(0, 2);
      we    = 1'($urandom);
      lng   = 1'($urandom);
      addr  = 16'($urandom);
      data  = 16'($urandom);
      rdata = 16'($urandom);
      sel   = 2'($urandom);
      hi    = 8'($urandom);
      run_xfer(we, addr, data, sel, lng, hi, waits, kind, rdata,
               tail, s, l, e, md, ok, a);
      if (kind == 0 && !we) exp_mdata = rdata;
      exp_s = (kind == 3) ? TO : waits + 1;
      exp_l = exp_s + 1;
      n_checks++;
      if (l !== exp_l || s !== exp_s || a !== 1) begin
        n_errors++;
        $display("FAIL rnd%0d_timing: lat=%0d stb=%0d acks=%0d want %0d/%0d/1",
                 it, l, s, a, exp_l, exp_s);
      end
      n_checks++;
      if (e !== (kind != 0) || md !== exp_mdata || ok !== 1'b1) begin
        n_errors++;
        $display("FAIL rnd%0d_resp: exc=%b md=%h ok=%b want %b/%h/1",
                 it, e, md, ok, kind != 0, exp_mdata);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_mdata = 16'h0000;
    rst      = 1'b1;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    mem_sel  = '0;
    mem_long = 1'b0;
    mem_hi   = '0;
    wb_dat   = '0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_read_zero_wait;
    test_long_write;
    test_bus_error;
    test_timeout;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
